// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: active-high hex glyph table,
// all-off segment pattern and the largest supported digit count.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  // Segment vectors are {g,f,e,d,c,b,a}; a 1 lights the segment.
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-glyph decode in active-high form; the parent applies pin polarity.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadow commit.
// Define SEG7_DIM_EN to add a 4-bit brightness input driving PWM gating of the digit selects.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SEG7_DIM_EN
  input  logic [3:0]              brightness,
`endif
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    pending,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic                    frame_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]  SegOffLvl = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic        DpOffLvl  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SelOffLvl = SEL_ACTIVE_LOW ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("NUM_DIGITS must be within 1..MAX_DIGITS");
  end
  if (REFRESH_DIV < 4) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be at least 4");
  end

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_out_q, seg_out_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic                    slot_tick;

  assign slot_tick  = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign frame_tick = slot_tick && (idx_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_tick) begin
      cnt_d = '0;
      idx_d = frame_tick ? '0 : idx_q + 1'b1;
    end
  end

  // Commit reads the old shadow; a simultaneous load refills it and keeps pending set.
  always_comb begin
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    if (frame_tick && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end
    if (load) begin
      shadow_data_d  = data_in;
      shadow_dp_d    = dp_in;
      shadow_blank_d = blank_in;
      pending_d      = 1'b1;
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [6:0]            cur_seg, seg_lit;
  logic                  dp_lit;
  logic [NUM_DIGITS-1:0] sel_lit;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib   = active_data_q[4*k +: 4];
        cur_dp    = active_dp_q[k];
        cur_blank = active_blank_q[k];
      end
    end
  end

  seg7_hex_decoder u_hex_decoder (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

`ifdef SEG7_DIM_EN
  logic [3:0] pwm_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= '0;
    else        pwm_q <= pwm_q + 4'd1;
  end
`endif

  always_comb begin
    seg_lit = cur_blank ? SEG_OFF : cur_seg;
    dp_lit  = cur_dp & ~cur_blank;
    sel_lit = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) sel_lit[k] = 1'b1;
    end
    // First cycle of each slot keeps every digit dark while segments settle.
    if (cnt_q == '0) sel_lit = '0;
`ifdef SEG7_DIM_EN
    if (pwm_q >= brightness) sel_lit = '0;
`endif
    seg_out_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_out_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    seg_sel_d = SEL_ACTIVE_LOW ? ~sel_lit : sel_lit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '1;
      pending_q      <= 1'b0;
      seg_out_q      <= SegOffLvl;
      dp_out_q       <= DpOffLvl;
      seg_sel_q      <= SelOffLvl;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      seg_out_q      <= seg_out_d;
      dp_out_q       <= dp_out_d;
      seg_sel_q      <= seg_sel_d;
    end
  end

  assign pending = pending_q;
  assign seg_out = seg_out_q;
  assign dp_out  = dp_out_q;
  assign seg_sel = seg_sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at NUM_DIGITS=4, REFRESH_DIV=4, active-low pins.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in, blank_in;
  logic        load;
  logic        pending, dp_out, frame_tick;
  logic [6:0]  seg_out;
  logic [3:0]  seg_sel;
`ifdef SEG7_DIM_EN
  logic [3:0]  brightness = 4'd15;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SEG7_DIM_EN
    .brightness (brightness),
`endif
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .pending    (pending),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .seg_sel    (seg_sel),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [3:0] sel;
    logic       ft;
  } trace_t;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  trace_t trace [16];
  vec_t   vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  task automatic wait_ft(input string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_tick got %b expected 1 within 40 cycles", name, frame_tick);
    end
  endtask

  // Entered at the negedge right after the commit edge; samples the middle of each slot.
  task automatic check_frame(input string name, input logic [3:0][6:0] exp_seg,
                             input logic [3:0] exp_dp);
    logic [3:0] sel_exp;
    step(2);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step(4);
      sel_exp = ~(4'b0001 << d);
      chk($sformatf("%s sel d%0d", name, d), 32'(seg_sel), 32'(sel_exp));
      chk($sformatf("%s seg d%0d", name, d), 32'(seg_out), 32'(exp_seg[d]));
      chk($sformatf("%s dp d%0d", name, d), 32'(dp_out), 32'(exp_dp[d]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    reset = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; load = 1'b0;

    trace = '{'{4'hF, 1'b0}, '{4'hE, 1'b0}, '{4'hE, 1'b0}, '{4'hE, 1'b0},
              '{4'hF, 1'b0}, '{4'hD, 1'b0}, '{4'hD, 1'b0}, '{4'hD, 1'b0},
              '{4'hF, 1'b0}, '{4'hB, 1'b0}, '{4'hB, 1'b0}, '{4'hB, 1'b0},
              '{4'hF, 1'b0}, '{4'h7, 1'b0}, '{4'h7, 1'b1}, '{4'h7, 1'b0}};

    vecs[0] = '{16'h12AF, 4'h0, 4'h0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vecs[1] = '{16'h0123, 4'h0, 4'h0, {7'h40, 7'h79, 7'h24, 7'h30}, 4'hF};
    vecs[2] = '{16'h4567, 4'hF, 4'h0, {7'h19, 7'h12, 7'h02, 7'h78}, 4'h0};
    vecs[3] = '{16'h89BC, 4'h0, 4'h0, {7'h00, 7'h10, 7'h03, 7'h46}, 4'hF};
    vecs[4] = '{16'hDE00, 4'hC, 4'h8, {7'h7F, 7'h06, 7'h40, 7'h40}, 4'hB};
    vecs[5] = '{16'h0D00, 4'h3, 4'h1, {7'h40, 7'h21, 7'h40, 7'h7F}, 4'hD};

    step(3);
    chk("reset seg_out", 32'(seg_out), 32'h7F);
    chk("reset dp_out", 32'(dp_out), 32'h1);
    chk("reset seg_sel", 32'(seg_sel), 32'hF);
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset frame_tick", 32'(frame_tick), 32'h0);

    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      chk($sformatf("idle sel c%0d", k), 32'(seg_sel), 32'(trace[k].sel));
      chk($sformatf("idle seg c%0d", k), 32'(seg_out), 32'h7F);
      chk($sformatf("idle ft c%0d", k), 32'(frame_tick), 32'(trace[k].ft));
    end

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
      chk($sformatf("vec%0d pending after load", i), 32'(pending), 32'h1);
      wait_ft($sformatf("vec%0d wait", i));
      chk($sformatf("vec%0d pending at ft", i), 32'(pending), 32'h1);
      step(1);
      chk($sformatf("vec%0d pending after commit", i), 32'(pending), 32'h0);
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpo);
    end

    // Two loads inside one frame: the second wins.
    wait_ft("double pre");
    step(1);
    do_load(16'h1111, 4'h0, 4'h0);
    step(1);
    do_load(16'h2222, 4'h0, 4'h0);
    chk("double pending", 32'(pending), 32'h1);
    wait_ft("double wait");
    step(1);
    chk("double pending cleared", 32'(pending), 32'h0);
    check_frame("double", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

    // Load landing on the commit edge.
    do_load(16'h7777, 4'h0, 4'h0);
    wait_ft("coinc wait");
    data_in = 16'h8888; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("coinc pending kept", 32'(pending), 32'h1);
    check_frame("coinc old", {7'h78, 7'h78, 7'h78, 7'h78}, 4'hF);
    wait_ft("coinc wait2");
    step(1);
    chk("coinc pending cleared", 32'(pending), 32'h0);
    check_frame("coinc new", {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF);

    // Reset while a load is pending must drop the shadow and blank the display.
    do_load(16'h5555, 4'h0, 4'h0);
    step(5);
    reset = 1'b0;
    step(1);
    chk("midrst seg_out", 32'(seg_out), 32'h7F);
    chk("midrst dp_out", 32'(dp_out), 32'h1);
    chk("midrst seg_sel", 32'(seg_sel), 32'hF);
    chk("midrst pending", 32'(pending), 32'h0);
    chk("midrst frame_tick", 32'(frame_tick), 32'h0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("midrst gap sel", 32'(seg_sel), 32'hF);
    step(1);
    chk("midrst d0 sel", 32'(seg_sel), 32'hE);
    chk("midrst d0 seg", 32'(seg_out), 32'h7F);
    wait_ft("midrst wait");
    chk("midrst pending at ft", 32'(pending), 32'h0);
    step(1);
    check_frame("midrst", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF);

`ifdef SEG7_DIM_EN
    brightness = 4'd4;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    act = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (seg_sel !== 4'hF) act++;
    end
    chk("dim b4 active cycles", 32'(act), 32'd3);
    brightness = 4'd15;
    act = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (seg_sel !== 4'hF) act++;
    end
    chk("dim b15 active cycles", 32'(act), 32'd11);
    brightness = 4'd0;
    act = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (seg_sel !== 4'hF) act++;
    end
    chk("dim b0 active cycles", 32'(act), 32'd0);
`else
    act = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
